// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
// Reset level, bubble value and boolean literals used across the slice.
package if_id_queue_pkg;

    localparam logic        RstAsserted = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        True_v      = 1'b1;
    localparam logic        False_v     = 1'b0;

endpackage : if_id_queue_pkg

// File: rtl/if_id_fifo_mem.sv
// DEPTH x WIDTH register array for the IF/ID queue.
// One synchronous write port at the tail, one combinational read port at the head.
module if_id_fifo_mem #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Storage is deliberately unreset; occupancy tracking makes stale data unobservable.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : if_id_fifo_mem

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry in-order buffer feeding a registered {pc, inst}.
// Empty-queue bypass keeps single-cycle latency; flush discards all wrong-path work.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              flush,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned DATA_W = ADDR_W + INST_W;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;

    logic              empty;
    logic              accept;
    logic              adv;
    logic              pop;
    logic              bypass;
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;

    assign if_ready = (count_q < CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

    assign accept = if_valid & if_ready & rdy & ~flush;
    assign adv    = rdy & ~id_stall & ~flush;
    assign pop    = adv & ~empty;
    // Bypass only when nothing is queued, so the new instruction cannot overtake older ones.
    assign bypass = adv & empty & accept;
    assign push   = accept & ~bypass;

    assign wdata                = {if_pc, if_inst};
    assign {head_pc, head_inst} = rdata;

    if_id_fifo_mem #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (tail_q),
        .wdata_i (wdata),
        .raddr_i (head_q),
        .rdata_o (rdata)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (rdy) begin
            if (flush) begin
                head_d  = tail_q;
                count_d = '0;
            end else begin
                if (push) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;

        if (rdy) begin
            if (flush) begin
                id_valid_d = False_v;
                id_pc_d    = ADDR_W'(ZeroWord);
                id_inst_d  = INST_W'(ZeroWord);
            end else if (adv) begin
                if (pop) begin
                    id_valid_d = True_v;
                    id_pc_d    = head_pc;
                    id_inst_d  = head_inst;
                end else if (bypass) begin
                    id_valid_d = True_v;
                    id_pc_d    = if_pc;
                    id_inst_d  = if_inst;
                end else begin
                    id_valid_d = False_v;
                    id_pc_d    = ADDR_W'(ZeroWord);
                    id_inst_d  = INST_W'(ZeroWord);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstAsserted) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            id_valid_q <= False_v;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign count    = count_q;

endmodule : if_id_queue
